// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port
// between the I-side (requester 0) and D-side (requester 1) cache controllers.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s0_strobe,
   input  logic              s0_rw,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic [DATA_W-1:0] s0_wdata,
   output logic              s0_rdy,
   output logic [DATA_W-1:0] s0_rdata,
   input  logic              s1_strobe,
   input  logic              s1_rw,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic [DATA_W-1:0] s1_wdata,
   output logic              s1_rdy,
   output logic [DATA_W-1:0] s1_rdata,
   output logic              m_strobe,
   output logic              m_rw,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              grant,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic              m_rw_q, m_rw_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [DATA_W-1:0] s0_rdata_q, s0_rdata_d;
   logic [DATA_W-1:0] s1_rdata_q, s1_rdata_d;
   logic              win;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      m_rw_d       = m_rw_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      s0_rdata_d   = s0_rdata_q;
      s1_rdata_d   = s1_rdata_q;
      win          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s0_strobe || s1_strobe) begin
               // On a tie the side that did not win last time goes first
               win       = (s0_strobe && s1_strobe) ? ~last_grant_q : s1_strobe;
               grant_d   = win;
               m_rw_d    = win ? s1_rw    : s0_rw;
               m_addr_d  = win ? s1_addr  : s0_addr;
               m_wdata_d = win ? s1_wdata : s0_wdata;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!m_rw_q) begin
                  if (grant_q) s1_rdata_d = m_rdata;
                  else         s0_rdata_d = m_rdata;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         m_rw_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         s0_rdata_q   <= '0;
         s1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_rw_q       <= m_rw_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         s0_rdata_q   <= s0_rdata_d;
         s1_rdata_q   <= s1_rdata_d;
      end
   end

   assign m_strobe = (state_q == S_ISSUE);
   assign busy     = (state_q != S_IDLE);
   assign s0_rdy   = (state_q == S_DONE) && !grant_q;
   assign s1_rdy   = (state_q == S_DONE) &&  grant_q;
   assign m_rw     = m_rw_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign grant    = grant_q;
   assign s0_rdata = s0_rdata_q;
   assign s1_rdata = s1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: table-driven single transactions plus hand sequences
// for arbitration, command hold, mid-access reset and a MEM_LAT=1 build.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        s0_strobe, s0_rw, s1_strobe, s1_rw;
   logic [15:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
   logic        s0_rdy, s1_rdy, m_strobe, m_rw, grant, busy;
   logic [15:0] s0_rdata, s1_rdata, m_addr, m_wdata, m_rdata;

   logic        a_s0_strobe, a_s0_rw, a_s1_strobe, a_s1_rw;
   logic [15:0] a_s0_addr, a_s0_wdata, a_s1_addr, a_s1_wdata;
   logic        a_s0_rdy, a_s1_rdy, a_m_strobe, a_m_rw, a_grant, a_busy;
   logic [15:0] a_s0_rdata, a_s1_rdata, a_m_addr, a_m_wdata, a_m_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Memory model: fixed pattern per address, with one tagged location
   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hC3C3);
   endfunction

   assign m_rdata   = mem_f(m_addr);
   assign a_m_rdata = mem_f(a_m_addr);

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) u_dut (
      .clk(clk), .reset(reset),
      .s0_strobe(s0_strobe), .s0_rw(s0_rw), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
      .s0_rdy(s0_rdy), .s0_rdata(s0_rdata),
      .s1_strobe(s1_strobe), .s1_rw(s1_rw), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
      .s1_rdy(s1_rdy), .s1_rdata(s1_rdata),
      .m_strobe(m_strobe), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .grant(grant), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut_lat1 (
      .clk(clk), .reset(reset),
      .s0_strobe(a_s0_strobe), .s0_rw(a_s0_rw), .s0_addr(a_s0_addr), .s0_wdata(a_s0_wdata),
      .s0_rdy(a_s0_rdy), .s0_rdata(a_s0_rdata),
      .s1_strobe(a_s1_strobe), .s1_rw(a_s1_rw), .s1_addr(a_s1_addr), .s1_wdata(a_s1_wdata),
      .s1_rdy(a_s1_rdy), .s1_rdata(a_s1_rdata),
      .m_strobe(a_m_strobe), .m_rw(a_m_rw), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
      .m_rdata(a_m_rdata), .grant(a_grant), .busy(a_busy)
   );

   typedef struct {
      logic        side;
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_r0;
      logic [15:0] exp_r1;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_txn(input vec_t v);
      if (!v.side) begin
         s0_strobe = 1'b1; s0_rw = v.rw; s0_addr = v.addr; s0_wdata = v.wdata;
      end else begin
         s1_strobe = 1'b1; s1_rw = v.rw; s1_addr = v.addr; s1_wdata = v.wdata;
      end
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("m_strobe", 32'(m_strobe), 32'(k == 1));
         chk("s0_rdy", 32'(s0_rdy), 32'((k == 6) && !v.side));
         chk("s1_rdy", 32'(s1_rdy), 32'((k == 6) && v.side));
         chk("busy", 32'(busy), 32'(k <= 6));
         if (k <= 6) begin
            chk("m_addr", 32'(m_addr), 32'(v.addr));
            chk("m_rw", 32'(m_rw), 32'(v.rw));
            chk("grant", 32'(grant), 32'(v.side));
            if (v.rw) chk("m_wdata", 32'(m_wdata), 32'(v.wdata));
         end
         if (k == 6) begin
            if (!v.side) s0_strobe = 1'b0;
            else         s1_strobe = 1'b0;
         end
      end
      chk("s0_rdata", 32'(s0_rdata), 32'(v.exp_r0));
      chk("s1_rdata", 32'(s1_rdata), 32'(v.exp_r1));
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b1, 1'b1, 16'h1234, 16'hA5A5, 16'hBEEF, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 16'hC2C3};
      vecs[3] = '{1'b0, 1'b1, 16'h0200, 16'h5555, 16'hBEEF, 16'hC2C3};
      vecs[4] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hBEEF, 16'hC33C};

      reset = 1'b1;
      s0_strobe = 1'b0; s0_rw = 1'b0; s0_addr = '0; s0_wdata = '0;
      s1_strobe = 1'b0; s1_rw = 1'b0; s1_addr = '0; s1_wdata = '0;
      a_s0_strobe = 1'b0; a_s0_rw = 1'b0; a_s0_addr = '0; a_s0_wdata = '0;
      a_s1_strobe = 1'b0; a_s1_rw = 1'b0; a_s1_addr = '0; a_s1_wdata = '0;
      tick();
      tick();
      chk("rst_m_strobe", 32'(m_strobe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_s0_rdy", 32'(s0_rdy), 32'd0);
      chk("rst_s1_rdy", 32'(s1_rdy), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_m_addr", 32'(m_addr), 32'd0);
      chk("rst_m_rw", 32'(m_rw), 32'd0);
      chk("rst_s0_rdata", 32'(s0_rdata), 32'd0);
      chk("rst_s1_rdata", 32'(s1_rdata), 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) do_txn(vecs[i]);

      // Both strobes held from reset: grants alternate 0,1,0,1, 7 cycles apart
      pulse_reset();
      s0_strobe = 1'b1; s0_rw = 1'b0; s0_addr = 16'h0A00;
      s1_strobe = 1'b1; s1_rw = 1'b0; s1_addr = 16'h0B00;
      for (int c = 1; c <= 28; c++) begin
         tick();
         chk("rr_m_strobe", 32'(m_strobe), 32'((c % 7) == 1));
         chk("rr_s0_rdy", 32'(s0_rdy), 32'((c == 6) || (c == 20)));
         chk("rr_s1_rdy", 32'(s1_rdy), 32'((c == 13) || (c == 27)));
         if ((c % 7) == 1) chk("rr_grant", 32'(grant), 32'(((c - 1) / 7) % 2));
         if (c == 27) begin
            s0_strobe = 1'b0;
            s1_strobe = 1'b0;
         end
      end
      chk("rr_idle", 32'(busy), 32'd0);
      chk("rr_s0_rdata", 32'(s0_rdata), 32'hC9C3);
      chk("rr_s1_rdata", 32'(s1_rdata), 32'hC8C3);

      // Command changed during WAIT must be ignored
      s0_strobe = 1'b1; s0_rw = 1'b0; s0_addr = 16'h0010;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 3) begin
            s0_addr = 16'h0020;
            s0_rw   = 1'b1;
         end
         chk("hold_m_addr", 32'(m_addr), 32'h0010);
         chk("hold_m_rw", 32'(m_rw), 32'd0);
         chk("hold_s0_rdy", 32'(s0_rdy), 32'(k == 6));
      end
      s0_strobe = 1'b0; s0_rw = 1'b0;
      tick();
      chk("hold_s0_rdata", 32'(s0_rdata), 32'hC3D3);

      // Asynchronous reset in the middle of WAIT abandons the access
      s0_strobe = 1'b1; s0_addr = 16'h0300;
      tick();
      tick();
      tick();
      chk("arst_pre_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_m_strobe", 32'(m_strobe), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_s0_rdy", 32'(s0_rdy), 32'd0);
      chk("arst_s0_rdata", 32'(s0_rdata), 32'd0);
      s0_strobe = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("arst_no_rdy", 32'({s0_rdy, s1_rdy, busy}), 32'd0);
      end
      do_txn('{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 16'hC7C3});

      // MEM_LAT=1 build: rdy at T+3
      a_s0_strobe = 1'b1; a_s0_rw = 1'b0; a_s0_addr = 16'h0040;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("l1_m_strobe", 32'(a_m_strobe), 32'(k == 1));
         chk("l1_s0_rdy", 32'(a_s0_rdy), 32'(k == 3));
         chk("l1_busy", 32'(a_busy), 32'(k <= 3));
         if (k == 3) a_s0_strobe = 1'b0;
      end
      chk("l1_s0_rdata", 32'(a_s0_rdata), 32'hBEEF);
      chk("l1_s1_rdy", 32'(a_s1_rdy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two cache controllers: requester 0 is the I-side and requester 1 is the D-side.
- Arbitrates round-robin and latches the winner's command, then issues a one-cycle memory strobe.
- Times the fixed memory latency with an internal counter, which replaces the external counter/CtrSig pair in the cache FSM.
- Returns a one-cycle ready pulse, plus read data on reads, to the granted requester.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 4, memory access latency in cycles (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
s0_strobe  in  1  requester 0 access request (level)
s0_rw  in  1  requester 0 direction: 1=write, 0=read
s0_addr  in  ADDR_W  requester 0 address
s0_wdata  in  DATA_W  requester 0 write data
s0_rdy  out  1  requester 0 completion pulse
s0_rdata  out  DATA_W  requester 0 read data
s1_strobe, s1_rw, s1_addr, s1_wdata, s1_rdy, s1_rdata  same as s0_*, for requester 1
m_strobe  out  1  memory access strobe
m_rw  out  1  memory direction: 1=write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data
grant  out  1  index of the current or last granted requester
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs=0; last_grant=1 so requester 0 wins the first tie; counter=0.
- Reset asserted mid-access abandons the transfer: m_strobe drops at once and no rdy is ever issued for that access.
- Registered state machine with states IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - Strobes are sampled only in IDLE.
  - If exactly one strobe is high, that requester wins.
  - If both are high, the requester != last_grant wins.
  - On a win: latch the winner's rw/addr/wdata into m_rw/m_addr/m_wdata, set grant, go to ISSUE.
  - If no strobe is high, stay in IDLE.
- ISSUE: m_strobe=1 for exactly this cycle; load counter with MEM_LAT-1; go to WAIT.
- WAIT:
  - m_strobe=0; m_rw/m_addr/m_wdata are held stable.
  - While counter != 0, decrement it.
  - When counter==0: if the access is a read, capture m_rdata into the granted requester's sN_rdata; then go to DONE.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- DONE: the granted requester's sN_rdy=1 for exactly one cycle; last_grant<=grant; go to IDLE.
- Latency: strobe high in IDLE cycle T gives ISSUE at T+1 and rdy at T+MEM_LAT+2.
  - Minimum request-to-request spacing on the memory port is MEM_LAT+3 cycles.
- Requester protocol:
  - Hold strobe and command stable until rdy is seen.
  - Deassert strobe on the edge ending the rdy cycle, unless issuing a back-to-back request.
  - A strobe still high in the IDLE cycle after DONE is treated as a new request.
- The non-granted requester's rdy stays 0 and its rdata holds its previous value.
- A write leaves the requester's rdata unchanged.
- Changes to any requester input outside IDLE are ignored; the latched command is used.
- Starvation freedom: with both strobes held high continuously, grants strictly alternate 0,1,0,1.
- m_rw/m_addr/m_wdata keep their last value in IDLE; grant keeps the last winner.

Test Plan:
- Reset then s0 read of addr 0x0040, memory returns 0xBEEF, MEM_LAT=4 -> m_strobe high only in cycle T+1 with m_addr=0x0040 and m_rw=0; s0_rdy pulses at T+6; s0_rdata=0xBEEF; s1_rdy stays 0.
- s1 write of addr 0x1234 with data 0xA5A5 -> m_rw=1, m_wdata=0xA5A5 held through WAIT; s1_rdy at T+6; s1_rdata unchanged.
- Both strobes high continuously from reset for 4 accesses -> grant sequence 0,1,0,1; each rdy goes only to the granted side; m_strobe spacing is 7 cycles.
- s0 changes its addr from 0x0010 to 0x0020 during WAIT -> m_addr stays 0x0010 until DONE.
- reset pulsed during WAIT of an s0 read -> m_strobe, busy, rdy and rdata return to 0 immediately; next s1 request completes normally at T+6.
- MEM_LAT=1 build: s0 read -> WAIT lasts one cycle and s0_rdy at T+3.
